// File: rtl/ps2_kbd_rx_pkg.sv
// Shared scancode constants, frame FSM states and set-2 to ASCII lookup
// for the keyboard path of the message-forwarding engine.
package mfe_kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_ESC    = 8'h76;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } fr_state_e;

    // Returns {hit, ascii}; hit=0 for codes outside the printable set.
    function automatic logic [8:0] sc_to_ascii(
        input logic [7:0] sc,
        input logic       shift
    );
        logic [7:0] ch;
        logic       hit;
        hit = 1'b1;
        ch  = 8'h00;
        case (sc)
            8'h1C: ch = "a";
            8'h32: ch = "b";
            8'h21: ch = "c";
            8'h23: ch = "d";
            8'h24: ch = "e";
            8'h2B: ch = "f";
            8'h34: ch = "g";
            8'h33: ch = "h";
            8'h43: ch = "i";
            8'h3B: ch = "j";
            8'h42: ch = "k";
            8'h4B: ch = "l";
            8'h3A: ch = "m";
            8'h31: ch = "n";
            8'h44: ch = "o";
            8'h4D: ch = "p";
            8'h15: ch = "q";
            8'h2D: ch = "r";
            8'h1B: ch = "s";
            8'h2C: ch = "t";
            8'h3C: ch = "u";
            8'h2A: ch = "v";
            8'h1D: ch = "w";
            8'h22: ch = "x";
            8'h35: ch = "y";
            8'h1A: ch = "z";
            8'h45: ch = "0";
            8'h16: ch = "1";
            8'h1E: ch = "2";
            8'h26: ch = "3";
            8'h25: ch = "4";
            8'h2E: ch = "5";
            8'h36: ch = "6";
            8'h3D: ch = "7";
            8'h3E: ch = "8";
            8'h46: ch = "9";
            8'h29: ch = " ";
            8'h49: ch = ".";
            8'h41: ch = ",";
            8'h4E: ch = "-";
            default: hit = 1'b0;
        endcase
        if (shift) begin
            if (ch >= "a" && ch <= "z") begin
                ch = ch - 8'h20;
            end else begin
                case (ch)
                    "0": ch = ")";
                    "1": ch = "!";
                    "2": ch = "@";
                    "3": ch = "#";
                    "4": ch = "$";
                    "5": ch = "%";
                    "6": ch = "^";
                    "7": ch = "&";
                    "8": ch = "*";
                    "9": ch = "(";
                    ".": ch = ">";
                    ",": ch = "<";
                    "-": ch = "_";
                    default: ch = ch;
                endcase
            end
        end
        return {hit, ch};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver: sync, clock filter,
// frame FSM with odd parity check and inter-edge timeout.
module ps2_frame_rx
    import mfe_kbd_pkg::*;
#(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] code,
    output logic       code_vld,
    output logic       frame_err
);

    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [FW-1:0] filt_cnt;
    logic          filt_clk;
    logic          filt_clk_d;
    logic          fall;
    logic          dat;

    fr_state_e     state;
    fr_state_e     state_nx;
    logic [7:0]    shreg;
    logic [7:0]    shreg_nx;
    logic [2:0]    bit_cnt;
    logic [2:0]    bit_cnt_nx;
    logic          par;
    logic          par_nx;
    logic          vld_nx;
    logic          err_nx;
    logic          err_q;
    logic [TW-1:0] to_cnt;
    logic          to_hit;

    // Idle-high reset values so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            dat_sync <= {dat_sync[0], ps2_data_i};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            filt_cnt   <= '0;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILT_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign fall   = filt_clk_d & ~filt_clk;
    assign dat    = dat_sync[1];
    assign to_hit = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == IDLE || fall) begin
            to_cnt <= '0;
        end else if (!to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nx   = state;
        shreg_nx   = shreg;
        bit_cnt_nx = bit_cnt;
        par_nx     = par;
        vld_nx     = 1'b0;
        err_nx     = 1'b0;
        if (to_hit) begin
            state_nx = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat) begin
                        state_nx   = DATA;
                        bit_cnt_nx = 3'd0;
                    end
                end
                DATA: begin
                    shreg_nx   = {dat, shreg[7:1]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = PARITY;
                end
                PARITY: begin
                    par_nx   = dat;
                    state_nx = STOP;
                end
                STOP: begin
                    if (dat && (^{shreg, par})) vld_nx = 1'b1;
                    else                        err_nx = 1'b1;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= 8'h00;
            bit_cnt  <= 3'd0;
            par      <= 1'b0;
            code_vld <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nx;
            shreg    <= shreg_nx;
            bit_cnt  <= bit_cnt_nx;
            par      <= par_nx;
            code_vld <= vld_nx;
            err_q    <= err_nx;
        end
    end

    assign code      = shreg;
    assign frame_err = err_q | to_hit;

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard front end: frame receiver plus set-2 scancode decoder
// producing ASCII, Enter and Escape pulses for the forwarding engine.
module ps2_kbd_rx
    import mfe_kbd_pkg::*;
#(
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic [7:0] kbd_data_o,
    output logic       kbd_valid_o,
    output logic       kbd_done_o,
    output logic       kbd_reset_o,
    output logic       frame_err_o
);

    logic [7:0] code;
    logic       code_vld;
    logic       fr_err;
    logic [8:0] lut;

    logic       ext, ext_nx;
    logic       brk, brk_nx;
    logic       lshift, lshift_nx;
    logic       rshift, rshift_nx;
    logic [7:0] data_nx;
    logic       valid_nx;
    logic       done_nx;
    logic       reset_nx;

    ps2_frame_rx #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_frame (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .code       (code),
        .code_vld   (code_vld),
        .frame_err  (fr_err)
    );

    assign lut = sc_to_ascii(code, lshift | rshift);

    always_comb begin
        ext_nx    = ext;
        brk_nx    = brk;
        lshift_nx = lshift;
        rshift_nx = rshift;
        data_nx   = kbd_data_o;
        valid_nx  = 1'b0;
        done_nx   = 1'b0;
        reset_nx  = 1'b0;
        if (code_vld) begin
            unique case (1'b1)
                code == SC_EXT: ext_nx = 1'b1;
                code == SC_BRK: brk_nx = 1'b1;
                default: begin
                    ext_nx = 1'b0;
                    brk_nx = 1'b0;
                    // Shift make is honoured even after E0 (fake shifts).
                    if (brk) begin
                        if (code == SC_LSHIFT) lshift_nx = 1'b0;
                        if (code == SC_RSHIFT) rshift_nx = 1'b0;
                    end else if (code == SC_LSHIFT) begin
                        lshift_nx = 1'b1;
                    end else if (code == SC_RSHIFT) begin
                        rshift_nx = 1'b1;
                    end else if (ext) begin
                        valid_nx = 1'b0;
                    end else if (code == SC_ENTER) begin
                        done_nx = 1'b1;
                    end else if (code == SC_ESC) begin
                        reset_nx = 1'b1;
                    end else if (lut[8]) begin
                        valid_nx = 1'b1;
                        data_nx  = lut[7:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext         <= 1'b0;
            brk         <= 1'b0;
            lshift      <= 1'b0;
            rshift      <= 1'b0;
            kbd_data_o  <= 8'h00;
            kbd_valid_o <= 1'b0;
            kbd_done_o  <= 1'b0;
            kbd_reset_o <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            ext         <= ext_nx;
            brk         <= brk_nx;
            lshift      <= lshift_nx;
            rshift      <= rshift_nx;
            kbd_data_o  <= data_nx;
            kbd_valid_o <= valid_nx;
            kbd_done_o  <= done_nx;
            kbd_reset_o <= reset_nx;
            frame_err_o <= fr_err;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed PS/2 keyboard bench with a table-driven keyboard model.
module tb_ps2_kbd_rx;

    localparam int FILT = 4;
    localparam int TO   = 400;
    localparam int HALF = 30;
    localparam int GAP  = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [7:0] kbd_data;
    logic       kbd_valid;
    logic       kbd_done;
    logic       kbd_reset;
    logic       frame_err;

    always #5 clk = ~clk;

    ps2_kbd_rx #(
        .FILT_LEN    (FILT),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_i   (ps2_clk),
        .ps2_data_i  (ps2_data),
        .kbd_data_o  (kbd_data),
        .kbd_valid_o (kbd_valid),
        .kbd_done_o  (kbd_done),
        .kbd_reset_o (kbd_reset),
        .frame_err_o (frame_err)
    );

    typedef enum int {EV_NONE, EV_CHAR, EV_DONE, EV_RST, EV_ERR} ev_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_valid = 0;
    int         n_done = 0;
    int         n_rst = 0;
    int         n_err = 0;
    bit         pend = 0;
    ev_t        exp_ev = EV_NONE;
    logic [7:0] exp_d = 8'h00;
    logic [7:0] held = 8'h00;
    int         t_min = 0;
    int         t_max = 0;
    logic       m_ext = 0, m_brk = 0, m_ls = 0, m_rs = 0;
    logic [7:0] seen[$];

    logic [7:0] sc_tab [40] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
        8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
        8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A,
        8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
        8'h29, 8'h49, 8'h41, 8'h4E
    };
    string lo_s = "abcdefghijklmnopqrstuvwxyz0123456789 .,-";
    string up_s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ)!@#$%^&*( ><_";

    task automatic fail_line(input string name, input int act, input int exp);
        errors++;
        $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) fail_line(name, act, exp);
    endtask

    // Keyboard model: what one accepted byte must produce.
    task automatic model_byte(input logic [7:0] b, output ev_t ev,
                              output logic [7:0] d);
        ev = EV_NONE;
        d  = 8'h00;
        if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            if (m_brk) begin
                if (b == 8'h12) m_ls = 0;
                if (b == 8'h59) m_rs = 0;
            end else if (b == 8'h12) begin
                m_ls = 1;
            end else if (b == 8'h59) begin
                m_rs = 1;
            end else if (!m_ext) begin
                if (b == 8'h5A) ev = EV_DONE;
                else if (b == 8'h76) ev = EV_RST;
                else begin
                    for (int i = 0; i < 40; i++) begin
                        if (sc_tab[i] == b) begin
                            ev = EV_CHAR;
                            d  = (m_ls | m_rs) ? up_s[i] : lo_s[i];
                        end
                    end
                end
            end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic arm(input ev_t ev, input logic [7:0] d,
                       input int lo, input int hi);
        if (ev != EV_NONE) begin
            pend   = 1;
            exp_ev = ev;
            exp_d  = d;
            t_min  = lo;
            t_max  = hi;
        end
    endtask

    // One clock cycle plus the per-cycle output comparison.
    task automatic tick();
        ev_t obs;
        @(negedge clk);
        cyc++;
        if (!rst) begin
            checks++;
            if (kbd_valid | kbd_done | kbd_reset | frame_err | (kbd_data != 0))
                fail_line("reset_outputs",
                          {kbd_data, 4'h0, kbd_valid, kbd_done, kbd_reset, frame_err}, 0);
            held = 8'h00;
            pend = 0;
            m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0;
        end else begin
            obs = EV_NONE;
            if (int'(kbd_valid) + int'(kbd_done) + int'(kbd_reset) > 1) begin
                checks++;
                fail_line("onehot", {kbd_valid, kbd_done, kbd_reset}, 0);
            end
            if (kbd_valid)      obs = EV_CHAR;
            else if (kbd_done)  obs = EV_DONE;
            else if (kbd_reset) obs = EV_RST;
            else if (frame_err) obs = EV_ERR;
            case (obs)
                EV_CHAR: n_valid++;
                EV_DONE: n_done++;
                EV_RST:  n_rst++;
                EV_ERR:  n_err++;
                default: ;
            endcase
            if (obs != EV_NONE) begin
                checks++;
                if (!pend) begin
                    fail_line("unexpected_event", int'(obs), int'(EV_NONE));
                end else begin
                    if (obs != exp_ev) fail_line("event_kind", int'(obs), int'(exp_ev));
                    else if (obs == EV_CHAR && kbd_data != exp_d)
                        fail_line("event_data", kbd_data, exp_d);
                    else if (cyc < t_min) fail_line("event_early", cyc, t_min);
                    if (exp_ev == EV_CHAR) begin
                        held = exp_d;
                        seen.push_back(exp_d);
                    end
                    pend = 0;
                end
            end else if (pend && cyc > t_max) begin
                checks++;
                fail_line("event_missing", int'(EV_NONE), int'(exp_ev));
                pend = 0;
            end
            if (!kbd_valid) begin
                checks++;
                if (kbd_data != held) fail_line("data_hold", kbd_data, held);
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Sends the first nbits of an 11-bit frame; a complete frame arms the model.
    task automatic send_bits(input logic [7:0] b, input bit bad, input int nbits,
                             output int last_fall);
        logic [10:0] fr;
        ev_t         ev;
        logic [7:0]  d;
        fr = {1'b1, (~^b) ^ bad, b, 1'b0};
        last_fall = cyc;
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            ticks(HALF);
            ps2_clk = 1'b0;
            last_fall = cyc;
            if (i == 10) begin
                if (bad) begin
                    ev = EV_ERR;
                    d  = 8'h00;
                end else begin
                    model_byte(b, ev, d);
                end
                arm(ev, d, cyc + 3, cyc + 25);
            end
            ticks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        ticks(GAP);
    endtask

    task automatic send(input logic [7:0] b);
        int lf;
        send_bits(b, 1'b0, 11, lf);
    endtask

    initial begin
        int lf;
        ticks(10);
        chk("reset_data", kbd_data, 8'h00);
        chk("reset_valid", kbd_valid, 0);
        rst = 1'b1;
        ticks(20);

        send(8'h1C);
        chk("a_data", held, 8'h61);
        chk("a_count", n_valid, 1);
        send(8'hF0);
        send(8'h1C);
        chk("a_release_silent", n_valid, 1);

        send(8'h12); send(8'h1C); send(8'h16);
        send(8'hF0); send(8'h12); send(8'h1C);
        chk("shift_count", seen.size(), 4);
        if (seen.size() == 4) begin
            chk("shift_A", seen[1], 8'h41);
            chk("shift_bang", seen[2], 8'h21);
            chk("unshift_a", seen[3], 8'h61);
        end

        send_bits(8'h1C, 1'b1, 11, lf);
        chk("parity_err", n_err, 1);
        chk("parity_no_char", n_valid, 4);
        send(8'h32);
        chk("b_data", held, 8'h62);

        send(8'h5A);
        send(8'h76);
        chk("enter_done", n_done, 1);
        chk("esc_reset", n_rst, 1);
        chk("enter_esc_no_char", n_valid, 5);
        send(8'hE0); send(8'h5A);
        chk("kp_enter_silent", n_done, 1);

        send(8'h59); send(8'h4E); send(8'hF0); send(8'h59); send(8'h29);
        chk("rshift_underscore", seen[5], 8'h5F);
        chk("space", seen[6], 8'h20);

        send_bits(8'h1C, 1'b0, 5, lf);
        arm(EV_ERR, 8'h00, lf + TO, lf + TO + 40);
        ticks(TO + 60);
        chk("timeout_err", n_err, 2);
        send(8'h45);
        chk("zero_data", held, 8'h30);

        send_bits(8'h1C, 1'b0, 5, lf);
        rst = 1'b0;
        ticks(3);
        chk("midreset_data", kbd_data, 8'h00);
        chk("midreset_err", frame_err, 0);
        ticks(7);
        rst = 1'b1;
        ticks(20);
        send(8'h1B);
        chk("s_data", held, 8'h73);
        chk("no_err_after_reset", n_err, 2);
        chk("total_chars", n_valid, 9);
        ticks(TO + 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
